// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB beat bus: MEM-side inputs with valid/ready, WB-side outputs with valid/ready.
// The stage sits behind the slave modport; the surrounding pipeline uses the master modport.
interface mem_wb_skid_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int RSRC_W = 2
);
  logic              valid_m;
  logic              ready_m;
  logic              RegWriteM;
  logic [RSRC_W-1:0] ResultSrcM;
  logic [WIDTH-1:0]  ReadDataM;
  logic [WIDTH-1:0]  ALUResultM;
  logic [REG_AW-1:0] RdM;
  logic [WIDTH-1:0]  PCPlus4M;

  logic              valid_w;
  logic              ready_w;
  logic              RegWriteW;
  logic [RSRC_W-1:0] ResultSrcW;
  logic [WIDTH-1:0]  ReadDataW;
  logic [WIDTH-1:0]  ALUResultW;
  logic [REG_AW-1:0] RdW;
  logic [WIDTH-1:0]  PCPlus4W;

  modport master (
    output valid_m, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, RdM, PCPlus4M, ready_w,
    input  ready_m, valid_w, RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W
  );

  modport slave (
    input  valid_m, RegWriteM, ResultSrcM, ReadDataM, ALUResultM, RdM, PCPlus4M, ready_w,
    output ready_m, valid_w, RegWriteW, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, x0-write kill and a
// saturating stall counter. ready_m/valid_w decode registered state only.
module mem_wb_skid_stage #(
  parameter int WIDTH        = 32,
  parameter int REG_AW       = 5,
  parameter int RSRC_W       = 2,
  parameter int ZERO_RD_KILL = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  mem_wb_skid_stage_if.slave       bus,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic              rw;
    logic [RSRC_W-1:0] rs;
    logic [WIDTH-1:0]  rdata;
    logic [WIDTH-1:0]  alu;
    logic [REG_AW-1:0] rd;
    logic [WIDTH-1:0]  pc;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   push;
  logic   pop;
  logic   valid_w;
  logic   ready_m;

  assign ready_m = (state_q != FULL);
  assign valid_w = (state_q != EMPTY);
  assign push    = bus.valid_m & ready_m;
  assign pop     = valid_w & bus.ready_w;

  always_comb begin
    in_beat       = '0;
    in_beat.rw    = bus.RegWriteM;
    in_beat.rs    = bus.ResultSrcM;
    in_beat.rdata = bus.ReadDataM;
    in_beat.alu   = bus.ALUResultM;
    in_beat.rd    = bus.RdM;
    in_beat.pc    = bus.PCPlus4M;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid_w && !bus.ready_w && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;

      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: if (push) begin
            main_q  <= in_beat;
            state_q <= ONE;
          end
          ONE: begin
            if (push && pop) begin
              main_q <= in_beat;
            end else if (push) begin
              skid_q  <= in_beat;
              state_q <= FULL;
            end else if (pop) begin
              state_q <= EMPTY;
            end
          end
          FULL: if (pop) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign bus.ready_m    = ready_m;
  assign bus.valid_w    = valid_w;
  assign bus.RegWriteW  = main_q.rw & valid_w &
                          !((ZERO_RD_KILL != 0) && (main_q.rd == '0));
  assign bus.ResultSrcW = main_q.rs;
  assign bus.ReadDataW  = main_q.rdata;
  assign bus.ALUResultW = main_q.alu;
  assign bus.RdW        = main_q.rd;
  assign bus.PCPlus4W   = main_q.pc;

endmodule
